// File: rtl/slot_reader.sv
// slot_reader: three-entry circular buffer. Pushes come from a clean write
// strobe. Pops come from a bouncing push-button, which is synchronized and
// then debounced. Each rising edge of the debounced level is one read request.
//
// Ports:
//   clk, rst_n      clock; asynchronous active-low reset
//   wr_data, wr_en  4-bit value pushed when wr_en=1 (single-cycle strobe)
//   rd_btn          raw asynchronous read button, active-high
//   clr             synchronous clear of buffer, flags and data_out
//   data_out        last popped value (registered)
//   rd_valid        one-cycle pulse in the cycle data_out updates
//   count           entries held (0..3); empty/full decoded from state
//   ovf, unf        sticky overflow / underflow flags
//   state_dbg       current FSM state (IDLE=0, READY=1, FULL=2)
//
// Handshake: wr_en and rd_req are fire-and-forget requests with no
// back-pressure. A request the buffer cannot honour is dropped, and ovf or
// unf records the drop.
module slot_reader #(
  parameter int DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] wr_data,
  input  logic       wr_en,
  input  logic       rd_btn,
  input  logic       clr,
  output logic [3:0] data_out,
  output logic       rd_valid,
  output logic [1:0] count,
  output logic       empty,
  output logic       full,
  output logic       ovf,
  output logic       unf,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES - 1);

  logic       sync1_q, sync2_q;
  logic [3:0] deb_cnt_q, deb_cnt_d;
  logic       deb_lvl_q, deb_lvl_d;
  logic       deb_prev_q;
  logic       rd_req;

  logic [3:0] mem_q [3];
  logic [3:0] mem_d [3];
  logic [1:0] head_q, head_d, tail_q, tail_d, count_q, count_d;
  logic [3:0] data_out_q, data_out_d;
  logic       rd_valid_q, rd_valid_d, ovf_q, ovf_d, unf_q, unf_d;
  state_t     state_q, state_d;
  logic       wr_ok, rd_ok;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Debouncer: a run of DEB_CYCLES cycles in which the synchronized level
  // differs from the accepted level flips the accepted level. Any agreeing
  // cycle restarts the run.
  always_comb begin
    deb_cnt_d = 4'd0;
    deb_lvl_d = deb_lvl_q;
    if (sync2_q != deb_lvl_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_lvl_d = ~deb_lvl_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 4'd1;
      end
    end
  end

  // One request per press. The release edge is ignored.
  assign rd_req = deb_lvl_q & ~deb_prev_q;

  // When FULL and a read arrives in the same cycle, the pop frees the slot,
  // so the write lands at tail (== head). The pop still returns the old
  // head value, because it reads mem_q.
  always_comb begin
    wr_ok = wr_en && ((state_q != ST_FULL) || rd_req);
    rd_ok = rd_req && (state_q != ST_IDLE);

    mem_d      = mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    rd_valid_d = 1'b0;
    ovf_d      = ovf_q;
    unf_d      = unf_q;

    if (clr) begin
      head_d     = 2'd0;
      tail_d     = 2'd0;
      count_d    = 2'd0;
      data_out_d = 4'd0;
      ovf_d      = 1'b0;
      unf_d      = 1'b0;
    end else begin
      if (wr_ok) begin
        mem_d[tail_q] = wr_data;
        tail_d        = ptr_inc(tail_q);
      end
      if (rd_ok) begin
        data_out_d = mem_q[head_q];
        head_d     = ptr_inc(head_q);
        rd_valid_d = 1'b1;
      end
      if (wr_en && (state_q == ST_FULL) && !rd_req) ovf_d = 1'b1;
      if (rd_req && (state_q == ST_IDLE)) unf_d = 1'b1;
      count_d = count_q + {1'b0, wr_ok} - {1'b0, rd_ok};
    end
  end

  // The state is always re-derived from the post-update count.
  always_comb begin
    state_d = ST_READY;
    case (count_d)
      2'd0:    state_d = ST_IDLE;
      2'd3:    state_d = ST_FULL;
      default: state_d = ST_READY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_cnt_q  <= 4'd0;
      deb_lvl_q  <= 1'b0;
      deb_prev_q <= 1'b0;
      mem_q      <= '{default: 4'd0};
      head_q     <= 2'd0;
      tail_q     <= 2'd0;
      count_q    <= 2'd0;
      data_out_q <= 4'd0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      sync1_q    <= rd_btn;
      sync2_q    <= sync1_q;
      deb_cnt_q  <= deb_cnt_d;
      deb_lvl_q  <= deb_lvl_d;
      deb_prev_q <= deb_lvl_q;
      mem_q      <= mem_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      state_q    <= state_d;
    end
  end

  assign data_out  = data_out_q;
  assign rd_valid  = rd_valid_q;
  assign count     = count_q;
  assign empty     = (state_q == ST_IDLE);
  assign full      = (state_q == ST_FULL);
  assign ovf       = ovf_q;
  assign unf       = unf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_slot_reader.sv
module tb_slot_reader;

  localparam int DEB  = 4;
  localparam int HOLD = 12;
  localparam int REL  = 8;

  localparam int OP_WR  = 0;
  localparam int OP_RD  = 1;
  localparam int OP_CLR = 2;
  localparam int OP_RW  = 3;

  logic       clk, rst_n, wr_en, rd_btn, clr;
  logic [3:0] wr_data, data_out;
  logic       rd_valid, empty, full, ovf, unf;
  logic [1:0] count, state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  slot_reader #(.DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en),
    .rd_btn(rd_btn), .clr(clr), .data_out(data_out), .rd_valid(rd_valid),
    .count(count), .empty(empty), .full(full), .ovf(ovf), .unf(unf),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / reference model ----------------
  // Transaction-level model: a queue of held values plus the flags.
  logic [3:0] exp_q[$];
  logic [3:0] m_dout;
  logic       m_ovf, m_unf;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clr();
    exp_q.delete();
    m_dout = 4'd0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic model_wr(input logic [3:0] d);
    if (exp_q.size() == 3) m_ovf = 1'b1;
    else exp_q.push_back(d);
  endtask

  // A read request with an optional write in the same cycle.
  task automatic model_rd(input logic do_wr, input logic [3:0] d, output int pulses);
    pulses = 0;
    if (exp_q.size() == 0) begin
      m_unf = 1'b1;
    end else begin
      m_dout = exp_q.pop_front();
      pulses = 1;
    end
    if (do_wr) exp_q.push_back(d);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drv_wr(input logic [3:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic drv_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Clean press: rd_btn is held for HOLD cycles and then released for REL
  // cycles. Negedge k after the press is the k-th sample. The read request is
  // live during the cycle before sample DEB+3, so an optional write driven at
  // sample DEB+2 coincides with it.
  task automatic drv_press(input logic do_wr, input logic [3:0] d,
                           output int pulses, output int first_k,
                           output logic [3:0] pulse_dout);
    pulses     = 0;
    first_k    = -1;
    pulse_dout = 4'd0;
    @(negedge clk);
    rd_btn = 1'b1;
    for (int k = 1; k <= HOLD + REL; k++) begin
      @(negedge clk);
      if (rd_valid) begin
        if (pulses == 0) begin
          first_k    = k;
          pulse_dout = data_out;
        end
        pulses++;
      end
      wr_en   = do_wr && (k == DEB + 2);
      wr_data = d;
      if (k == HOLD) rd_btn = 1'b0;
    end
    wr_en = 1'b0;
  endtask

  task automatic chk_outputs(input string tag, input int e_dout, input int e_cnt,
                             input int e_ovf, input int e_unf);
    chk({tag, ".data_out"}, data_out, e_dout);
    chk({tag, ".count"}, count, e_cnt);
    chk({tag, ".empty"}, empty, e_cnt == 0);
    chk({tag, ".full"}, full, e_cnt == 3);
    chk({tag, ".ovf"}, ovf, e_ovf);
    chk({tag, ".unf"}, unf, e_unf);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int         op;
    logic [3:0] data;
    int         e_dout;
    int         e_cnt;
    int         e_ovf;
    int         e_unf;
    int         e_pulses;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int op, input logic [3:0] d, input int dout, input int cnt,
                     input int o, input int u, input int p);
    vec_t v;
    v.op = op; v.data = d; v.e_dout = dout; v.e_cnt = cnt;
    v.e_ovf = o; v.e_unf = u; v.e_pulses = p;
    vecs.push_back(v);
  endtask

  task automatic apply_op(input int op, input logic [3:0] d, output int pulses,
                          output int first_k, output logic [3:0] pdout);
    pulses  = 0;
    first_k = -1;
    pdout   = 4'd0;
    case (op)
      OP_WR:   drv_wr(d);
      OP_CLR:  drv_clr();
      OP_RD:   drv_press(1'b0, d, pulses, first_k, pdout);
      default: drv_press(1'b1, d, pulses, first_k, pdout);
    endcase
  endtask

  initial begin
    int pulses, first_k, mp;
    logic [3:0] pdout;
    int op;
    logic [3:0] d;

    rst_n = 1'b0; wr_en = 1'b0; wr_data = 4'd0; rd_btn = 1'b0; clr = 1'b0;
    model_clr();
    repeat (3) @(negedge clk);
    chk_outputs("reset", 0, 0, 0, 0);
    chk("reset.rd_valid", rd_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // In-order delivery, overflow, underflow and clr, same-cycle read+write
    // when full, and same-cycle read+write when empty.
    add(OP_WR, 4'h3, 0, 1, 0, 0, 0);
    add(OP_WR, 4'h7, 0, 2, 0, 0, 0);
    add(OP_WR, 4'hA, 0, 3, 0, 0, 0);
    add(OP_RD, 4'h0, 3, 2, 0, 0, 1);
    add(OP_RD, 4'h0, 7, 1, 0, 0, 1);
    add(OP_RD, 4'h0, 10, 0, 0, 0, 1);
    add(OP_WR, 4'h1, 10, 1, 0, 0, 0);
    add(OP_WR, 4'h2, 10, 2, 0, 0, 0);
    add(OP_WR, 4'h4, 10, 3, 0, 0, 0);
    add(OP_WR, 4'h5, 10, 3, 1, 0, 0);
    add(OP_RD, 4'h0, 1, 2, 1, 0, 1);
    add(OP_RD, 4'h0, 2, 1, 1, 0, 1);
    add(OP_RD, 4'h0, 4, 0, 1, 0, 1);
    add(OP_RD, 4'h0, 4, 0, 1, 1, 0);
    add(OP_CLR, 4'h0, 0, 0, 0, 0, 0);
    add(OP_WR, 4'h6, 0, 1, 0, 0, 0);
    add(OP_WR, 4'h8, 0, 2, 0, 0, 0);
    add(OP_WR, 4'h9, 0, 3, 0, 0, 0);
    add(OP_RW, 4'hC, 6, 3, 0, 0, 1);
    add(OP_RD, 4'h0, 8, 2, 0, 0, 1);
    add(OP_RD, 4'h0, 9, 1, 0, 0, 1);
    add(OP_RD, 4'h0, 12, 0, 0, 0, 1);
    add(OP_RW, 4'h2, 12, 1, 0, 1, 0);
    add(OP_RD, 4'h0, 2, 0, 0, 1, 1);
    add(OP_CLR, 4'h0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      apply_op(vecs[i].op, vecs[i].data, pulses, first_k, pdout);
      chk_outputs($sformatf("vec%0d", i), vecs[i].e_dout, vecs[i].e_cnt,
                  vecs[i].e_ovf, vecs[i].e_unf);
      if (vecs[i].op == OP_RD || vecs[i].op == OP_RW) begin
        chk($sformatf("vec%0d.pulses", i), pulses, vecs[i].e_pulses);
        if (vecs[i].e_pulses == 1) begin
          chk($sformatf("vec%0d.latency", i), first_k, DEB + 3);
          chk($sformatf("vec%0d.pulse_dout", i), pdout, vecs[i].e_dout);
        end
      end
    end

    // Bounce rejection: high 3 / low 1 for 20 cycles must not pop anything.
    drv_wr(4'hE);
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rd_valid) pulses++;
      rd_btn = ((c % 4) != 3);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rd_valid) pulses++;
    end
    rd_btn = 1'b0;
    chk("bounce.pulses", pulses, 0);
    chk("bounce.count", count, 1);
    // A hold after the bounce pops exactly once, at the nominal latency.
    drv_press(1'b0, 4'h0, pulses, first_k, pdout);
    chk("hold.pulses", pulses, 1);
    chk("hold.latency", first_k, DEB + 3);
    chk("hold.dout", pdout, 4'hE);

    // Reset asserted mid-debounce with two entries held.
    drv_wr(4'h1);
    drv_wr(4'h2);
    @(negedge clk);
    rd_btn = 1'b1;
    repeat (3) @(negedge clk);
    rst_n  = 1'b0;
    rd_btn = 1'b0;
    #1;
    chk_outputs("rst_mid", 0, 0, 0, 0);
    chk("rst_mid.rd_valid", rd_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (rd_valid) pulses++;
    end
    chk("rst_mid.no_valid", pulses, 0);
    chk_outputs("rst_after", 0, 0, 0, 0);

    // A fresh press after reset, with the buffer empty, underflows exactly once.
    drv_press(1'b0, 4'h0, pulses, first_k, pdout);
    chk("rst_press.pulses", pulses, 0);
    chk("rst_press.unf", unf, 1);
    drv_clr();

    // Randomized operations checked against the transaction model.
    model_clr();
    for (int n = 0; n < 60; n++) begin
      int r;
      r = $urandom_range(0, 99);
      op = (r < 45) ? OP_WR : (r < 80) ? OP_RD : (r < 90) ? OP_RW : OP_CLR;
      d  = 4'($urandom_range(0, 15));
      apply_op(op, d, pulses, first_k, pdout);
      mp = 0;
      case (op)
        OP_WR:   model_wr(d);
        OP_CLR:  model_clr();
        OP_RD:   model_rd(1'b0, d, mp);
        default: model_rd(1'b1, d, mp);
      endcase
      chk_outputs($sformatf("rnd%0d", n), m_dout, exp_q.size(), m_ovf, m_unf);
      if (op == OP_RD || op == OP_RW) begin
        chk($sformatf("rnd%0d.pulses", n), pulses, mp);
        if (mp == 1) chk($sformatf("rnd%0d.latency", n), first_k, DEB + 3);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
